// File: rtl/muldiv_pkg.sv
// Shared types and constants for the RV32M multiply/divide unit.
// Optional build macro: MULDIV_FAST_MUL_EN (single-cycle multiplier).
package muldiv_pkg;

  typedef enum logic [2:0] {
    OP_MUL    = 3'b000,
    OP_MULH   = 3'b001,
    OP_MULHSU = 3'b010,
    OP_MULHU  = 3'b011,
    OP_DIV    = 3'b100,
    OP_DIVU   = 3'b101,
    OP_REM    = 3'b110,
    OP_REMU   = 3'b111
  } op_e;

  typedef enum logic [1:0] {
    S_IDLE,
    S_MUL,
    S_DIV,
    S_DONE
  } state_e;

  localparam int ITER_CNT = 32;
  localparam logic [31:0] DIV_OVF_DIVIDEND = 32'h8000_0000;

  function automatic logic a_signed(op_e op);
    return op inside {OP_MUL, OP_MULH, OP_MULHSU, OP_DIV, OP_REM};
  endfunction

  function automatic logic b_signed(op_e op);
    return op inside {OP_MUL, OP_MULH, OP_DIV, OP_REM};
  endfunction

endpackage

// File: rtl/muldiv_sign_fix.sv
// Restores the signs of quotient and remainder after magnitude division.
// Optional build macro: none (MULDIV_FAST_MUL_EN does not affect this file).
module muldiv_sign_fix (
  input  logic [31:0] quo_mag,
  input  logic [31:0] rem_mag,
  input  logic        neg_q,
  input  logic        neg_r,
  output logic [31:0] quo,
  output logic [31:0] rem
);

  assign quo = neg_q ? -quo_mag : quo_mag;
  assign rem = neg_r ? -rem_mag : rem_mag;

endmodule

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit with a 4-state FSM.
// Optional build macro: MULDIV_FAST_MUL_EN (single-cycle multiplier).
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] op_a,
  input  logic [XLEN-1:0] op_b,
  input  logic [4:0]      rd_in,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result,
  output logic [4:0]      rd_out
);

  state_e      state, state_nx;
  op_e         op;
  op_e         op_in;
  logic [31:0] a_r, b_r;
  logic [4:0]  rd_r;
  logic [63:0] acc, mcand;
  logic [31:0] mplier;
  logic [5:0]  cnt;

  logic        sb, last, div0, ovf, bypass, mul_fin, fits;
  logic [63:0] prod;
  logic [32:0] trial;
  logic [31:0] amag, bmag, quo_fix, rem_fix, fin;

  assign op_in = op_e'(funct3);
  assign sb    = b_signed(op);
  assign last  = cnt == 6'(ITER_CNT);
  assign div0  = b_r == 32'd0;
  assign ovf   = (op == OP_DIV || op == OP_REM)
              && a_r == DIV_OVF_DIVIDEND
              && b_r == 32'hFFFF_FFFF;
  assign bypass = div0 | ovf;

  // magnitudes for division; only DIV/REM treat operands as signed
  assign amag = (b_signed(op_in) && op_a[31]) ? -op_a : op_a;
  assign bmag = (b_signed(op_in) && op_b[31]) ? -op_b : op_b;

  // shifted partial remainder minus divisor; no borrow means the bit is 1
  assign trial = acc[63:31] - {1'b0, mcand[31:0]};
  assign fits  = ~trial[32];

`ifdef MULDIV_FAST_MUL_EN
  logic              sa;
  logic signed [32:0] fa, fb;
  assign sa      = a_signed(op);
  assign fa      = {sa & a_r[31], a_r};
  assign fb      = {sb & b_r[31], b_r};
  assign prod    = 64'(fa) * 64'(fb);
  assign mul_fin = 1'b1;
`else
  assign prod    = acc;
  assign mul_fin = last;
`endif

  muldiv_sign_fix u_sign_fix (
    .quo_mag (acc[31:0]),
    .rem_mag (acc[63:32]),
    .neg_q   (sb & (a_r[31] ^ b_r[31])),
    .neg_r   (sb & a_r[31]),
    .quo     (quo_fix),
    .rem     (rem_fix)
  );

  always_comb begin
    fin = '0;
    if (state == S_MUL)
      fin = (op == OP_MUL) ? prod[31:0] : prod[63:32];
    else if (div0)
      fin = op[1] ? a_r : 32'hFFFF_FFFF;
    else if (ovf)
      fin = op[1] ? 32'd0 : DIV_OVF_DIVIDEND;
    else
      fin = op[1] ? rem_fix : quo_fix;
  end

  always_ff @(posedge clk) begin
    if (!reset) state <= S_IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      S_IDLE:  if (start) state_nx = funct3[2] ? S_DIV : S_MUL;
      S_MUL:   if (mul_fin) state_nx = S_DONE;
      S_DIV:   if (bypass || last) state_nx = S_DONE;
      S_DONE:  state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  always_comb begin
    busy = state != S_IDLE;
    done = state == S_DONE;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      op     <= OP_MUL;
      a_r    <= '0;
      b_r    <= '0;
      rd_r   <= '0;
      acc    <= '0;
      mcand  <= '0;
      mplier <= '0;
      cnt    <= '0;
      result <= '0;
      rd_out <= '0;
    end else begin
      unique case (state)
        S_IDLE: if (start) begin
          op   <= op_in;
          a_r  <= op_a;
          b_r  <= op_b;
          rd_r <= rd_in;
          cnt  <= '0;
          if (!funct3[2]) begin
            acc    <= '0;
            mcand  <= {{32{a_signed(op_in) & op_a[31]}}, op_a};
            mplier <= op_b;
          end else begin
            acc    <= {32'd0, amag};
            mcand  <= {32'd0, bmag};
            mplier <= '0;
          end
        end
        S_MUL: if (mul_fin) begin
          result <= fin;
          rd_out <= rd_r;
        end else begin
          // bit 31 of a signed multiplier carries weight -2^31
          if (mplier[0])
            acc <= (cnt == 6'(ITER_CNT - 1) && sb) ? acc - mcand
                                                   : acc + mcand;
          mcand  <= {mcand[62:0], 1'b0};
          mplier <= {1'b0, mplier[31:1]};
          cnt    <= cnt + 6'd1;
        end
        S_DIV: if (bypass || last) begin
          result <= fin;
          rd_out <= rd_r;
        end else begin
          acc <= fits ? {trial[31:0], acc[30:0], 1'b1}
                      : {acc[62:0], 1'b0};
          cnt <= cnt + 6'd1;
        end
        S_DONE: ;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit with an arithmetic reference model.
// Honours MULDIV_FAST_MUL_EN for expected multiply latency.
module tb_muldiv_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [2:0]  funct3;
  logic [31:0] op_a, op_b;
  logic [4:0]  rd_in;
  logic        busy, done;
  logic [31:0] result;
  logic [4:0]  rd_out;

  int tests = 0;
  int fails = 0;

`ifdef MULDIV_FAST_MUL_EN
  localparam int MUL_LAT = 2;
`else
  localparam int MUL_LAT = 34;
`endif

  muldiv_unit #(.XLEN(32)) dut (
    .clk    (clk),
    .reset  (reset),
    .start  (start),
    .funct3 (funct3),
    .op_a   (op_a),
    .op_b   (op_b),
    .rd_in  (rd_in),
    .busy   (busy),
    .done   (done),
    .result (result),
    .rd_out (rd_out)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] ref_res(input logic [2:0] f,
                                          input logic [31:0] a,
                                          input logic [31:0] b);
    longint as_, bs_, au, bu;
    logic [63:0] p;
    logic ovf;
    as_ = longint'($signed(a));
    bs_ = longint'($signed(b));
    au  = longint'({32'd0, a});
    bu  = longint'({32'd0, b});
    ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    case (f)
      3'd0: begin p = 64'(au * bu); return p[31:0]; end
      3'd1: begin p = 64'(as_ * bs_); return p[63:32]; end
      3'd2: begin p = 64'(as_ * bu); return p[63:32]; end
      3'd3: begin p = 64'(au * bu); return p[63:32]; end
      3'd4: begin
        if (b == 0) return 32'hFFFF_FFFF;
        if (ovf) return 32'h8000_0000;
        return 32'($signed(a) / $signed(b));
      end
      3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
      3'd6: begin
        if (b == 0) return a;
        if (ovf) return 32'd0;
        return 32'($signed(a) % $signed(b));
      end
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  function automatic int ref_lat(input logic [2:0] f,
                                 input logic [31:0] a,
                                 input logic [31:0] b);
    if (!f[2]) return MUL_LAT;
    if (b == 0) return 2;
    if (!f[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 2;
    return 34;
  endfunction

  // caller is 1 time unit after a rising edge
  task automatic run_op(input string tag, input logic [2:0] f,
                        input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] rd);
    int lat;
    logic seen;
    start = 1'b1; funct3 = f; op_a = a; op_b = b; rd_in = rd;
    lat = 0;
    seen = 1'b0;
    while (lat < 60 && !seen) begin
      @(posedge clk); #1;
      lat++;
      start = 1'b0;
      op_a = $urandom; op_b = $urandom; rd_in = 5'($urandom);
      if (lat == 1) check({tag, "_busy"}, 64'(busy), 64'd1);
      if (done) seen = 1'b1;
    end
    check({tag, "_done"}, 64'(seen), 64'd1);
    check({tag, "_lat"}, 64'(lat), 64'(ref_lat(f, a, b)));
    check({tag, "_res"}, 64'(result), 64'(ref_res(f, a, b)));
    check({tag, "_rd"}, 64'(rd_out), 64'(rd));
    @(posedge clk); #1;
    check({tag, "_pulse"}, 64'(done), 64'd0);
    check({tag, "_idle"}, 64'(busy), 64'd0);
    check({tag, "_hold"}, 64'(result), 64'(ref_res(f, a, b)));
  endtask

  initial begin
    int lat, ndone;
    logic [31:0] ra, rb;
    logic [2:0]  rf;

    reset = 1'b0; start = 1'b0; funct3 = '0;
    op_a = '0; op_b = '0; rd_in = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_result", 64'(result), 64'd0);
    check("rst_rd", 64'(rd_out), 64'd0);
    reset = 1'b1;
    @(posedge clk); #1;

    run_op("mul_7x-3", 3'b000, 32'd7, 32'hFFFF_FFFD, 5'd1);
    check("mul_7x-3_val", 64'(result), 64'hFFFF_FFEB);
    run_op("mulhu_ff", 3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd2);
    check("mulhu_ff_val", 64'(result), 64'hFFFF_FFFE);
    run_op("mulh_ff", 3'b001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd3);
    check("mulh_ff_val", 64'(result), 64'd0);
    run_op("div_-7_2", 3'b100, 32'hFFFF_FFF9, 32'd2, 5'd4);
    check("div_-7_2_val", 64'(result), 64'hFFFF_FFFD);
    run_op("rem_-7_2", 3'b110, 32'hFFFF_FFF9, 32'd2, 5'd5);
    check("rem_-7_2_val", 64'(result), 64'hFFFF_FFFF);
    run_op("divu_5_0", 3'b101, 32'd5, 32'd0, 5'd6);
    check("divu_5_0_val", 64'(result), 64'hFFFF_FFFF);
    run_op("rem_ovf", 3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 5'd7);
    run_op("div_ovf", 3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 5'd8);
    run_op("remu_0", 3'b111, 32'h1234_5678, 32'd0, 5'd9);
    run_op("mulhsu_neg", 3'b010, 32'h8000_0000, 32'hFFFF_FFFF, 5'd10);

    for (int i = 0; i < 40; i++) begin
      rf = 3'($urandom_range(0, 7));
      ra = $urandom;
      rb = $urandom;
      if ($urandom_range(0, 3) == 0) rb = 32'($urandom_range(0, 3)) - 32'd1;
      if ($urandom_range(0, 5) == 0) ra = 32'h8000_0000;
      if ($urandom_range(0, 3) == 0) ra = 32'($urandom_range(0, 100));
      run_op("rand", rf, ra, rb, 5'($urandom));
    end

    // second start mid-operation must not disturb the divide in flight
    start = 1'b1; funct3 = 3'b100; op_a = 32'd100; op_b = 32'd7;
    rd_in = 5'd3;
    lat = 0; ndone = 0;
    while (lat < 45) begin
      @(posedge clk); #1;
      lat++;
      start = (lat == 9);
      if (lat == 9) begin
        funct3 = 3'b000; op_a = 32'd1; op_b = 32'd1; rd_in = 5'd9;
      end
      if (done) begin
        ndone++;
        if (ndone == 1) begin
          check("ign_lat", 64'(lat), 64'd34);
          check("ign_res", 64'(result), 64'd14);
          check("ign_rd", 64'(rd_out), 64'd3);
        end
      end
    end
    check("ign_ndone", 64'(ndone), 64'd1);

    // reset during a divide aborts it and drops a simultaneous start
    start = 1'b1; funct3 = 3'b100; op_a = 32'd1000; op_b = 32'd3;
    rd_in = 5'd17;
    lat = 0;
    while (lat < 19) begin
      @(posedge clk); #1;
      lat++;
      start = 1'b0;
    end
    reset = 1'b0; start = 1'b1; funct3 = 3'b000;
    @(posedge clk); #1;
    check("mrst_busy", 64'(busy), 64'd0);
    check("mrst_done", 64'(done), 64'd0);
    check("mrst_res", 64'(result), 64'd0);
    check("mrst_rd", 64'(rd_out), 64'd0);
    reset = 1'b1; start = 1'b0;
    ndone = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (done) ndone++;
    end
    check("mrst_nodone", 64'(ndone), 64'd0);
    check("mrst_idle", 64'(busy), 64'd0);

    run_op("post_rst", 3'b101, 32'd1000, 32'd3, 5'd21);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/muldiv_unit.md
MULDIV_UNIT -- requirements
Module: muldiv_unit

Interface
REQ-001 Parameter XLEN, default 32, operand and result width; only 32 is supported.
REQ-002 Port clk  input  1  the single clock; all state changes on its rising edge.
REQ-003 Port reset  input  1  synchronous, active-low reset (asserted when 0, sampled on clk).
REQ-004 Port start  input  1  request pulse; accepted only in IDLE.
REQ-005 Port funct3  input  3  RV32M op: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
REQ-006 Port op_a  input  32  rs1 value, from the register file read port 1.
REQ-007 Port op_b  input  32  rs2 value, from the register file read port 2.
REQ-008 Port rd_in  input  5  destination register tag, carried through.
REQ-009 Port busy  output  1  high while an accepted operation is in flight.
REQ-010 Port done  output  1  single-cycle pulse; result and rd_out are valid that cycle.
REQ-011 Port result  output  32  operation result.
REQ-012 Port rd_out  output  5  rd_in captured at acceptance.

Function
REQ-013 The FSM SHALL have the states IDLE, MUL, DIV and DONE.
REQ-014 In IDLE, start=1 SHALL capture funct3, op_a, op_b and rd_in. The FSM SHALL go to MUL (funct3[2]=0) or DIV (funct3[2]=1).
REQ-015 start while not in IDLE SHALL be ignored, with no effect on the operation in flight.
REQ-016 busy SHALL be 1 in MUL, DIV and DONE, and 0 in IDLE.
REQ-017 MUL SHALL iterate one shift-add step per cycle for exactly 32 cycles on a 64-bit product. Operands SHALL be sign- or zero-extended per funct3.
REQ-018 DIV SHALL run restoring division on magnitudes, one quotient bit per cycle, for exactly 32 cycles. Signs SHALL be fixed up on exit: quotient negative iff the operand signs differ; remainder takes the sign of op_a.
REQ-019 Iterative latency: start accepted at edge N; done=1 in the cycle after edge N+33; the FSM returns to IDLE at edge N+34.
REQ-020 MUL SHALL return product[31:0]. MULH, MULHSU and MULHU SHALL return product[63:32].
REQ-021 Divide by zero (op_b=0) SHALL bypass iteration and go straight to DONE. DIV/DIVU SHALL return 32'hFFFFFFFF; REM/REMU SHALL return op_a.
REQ-022 Signed overflow (DIV/REM, op_a=32'h80000000, op_b=32'hFFFFFFFF) SHALL bypass iteration. DIV SHALL return 32'h80000000; REM SHALL return 0.
REQ-023 Bypass latency: done=1 in the cycle after edge N+1.
REQ-024 result and rd_out SHALL be registered and hold their last values after done until the next done.
REQ-025 done SHALL never be high for two consecutive cycles.

Reset
REQ-026 reset=0 at a clk edge SHALL force IDLE and clear busy, done, result, rd_out and all datapath registers to 0.
REQ-027 reset mid-operation SHALL abort the operation with no done pulse. A start sampled with reset=0 SHALL be dropped.

Configuration
REQ-028 Macro MULDIV_FAST_MUL_EN.
REQ-029 With MULDIV_FAST_MUL_EN defined, MUL-class ops SHALL compute in one cycle with a combinational 33x33 signed multiplier. They SHALL go IDLE to DONE with bypass latency.
REQ-030 Without MULDIV_FAST_MUL_EN, the MUL state SHALL exist and iterate per REQ-017. Division SHALL be identical in both builds.

Structure
REQ-031 Package muldiv_pkg SHALL hold the funct3 op enum, the FSM state enum, and the constants ITER_CNT=32 and DIV_OVF_DIVIDEND=32'h80000000.
REQ-032 The combinational sign fix-up SHALL be the sub-module muldiv_sign_fix, instanced once.

Verification
REQ-033 MUL 7 x -3 -> done 34 cycles after start (iterative), result=32'hFFFFFFEB; with MULDIV_FAST_MUL_EN, done after 2 cycles.
REQ-034 MULHU 32'hFFFFFFFF x 32'hFFFFFFFF -> result=32'hFFFFFFFE; MULH of the same operands -> result=0.
REQ-035 DIV -7 / 2 -> result=32'hFFFFFFFD; REM -7 / 2 -> result=32'hFFFFFFFF; rd_out equals rd_in given at start.
REQ-036 DIVU 5 / 0 -> done after 2 cycles, result=32'hFFFFFFFF; REM 32'h80000000 / 32'hFFFFFFFF -> result=0.
REQ-037 Start a DIV, pulse start again at cycle 10 -> ignored, single done at cycle 34; reset=0 at cycle 20 of a new DIV -> no done, busy=0, result=0.
